alu_cmd_sequencer: RTL and testbench
====================================

# alu_cmd_sequencer

Command sequencer that sits directly upstream of the 8-bit combinational ALU (`a`, `b`, `cl` → `out`). It accepts operation and load commands over a valid/ready handshake and holds a small operand register file. It drives the ALU operand and opcode inputs from that register file, captures the ALU result back into a destination register, and presents each result on a valid/ready output with a completion counter.

## Interface
- `WIDTH`, 8, data width; matches ALU `a`/`b`/`out`
- `OPW`, 4, opcode width; matches ALU `cl`
- `NREG`, 4, register file depth; register index width is 2 bits (fixed for NREG=4)

- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  sequencer can accept; command accepted on an edge where both are high
- `cmd_load`  in  1  1 = load `cmd_imm` into `cmd_dst`; 0 = ALU operation
- `cmd_op`  in  OPW  ALU opcode (ignored when `cmd_load`=1)
- `cmd_src_a`  in  2  register index for ALU `a`
- `cmd_src_b`  in  2  register index for ALU `b`
- `cmd_dst`  in  2  destination register index
- `cmd_imm`  in  WIDTH  immediate for load
- `alu_a`  out  WIDTH  to ALU `a`, registered
- `alu_b`  out  WIDTH  to ALU `b`, registered
- `alu_cl`  out  OPW  to ALU `cl`, registered
- `alu_out`  in  WIDTH  from ALU `out`, combinational function of `alu_a`/`alu_b`/`alu_cl`
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer takes result
- `res_data`  out  WIDTH  result value (ALU output or loaded immediate)
- `res_dst`  out  2  register index written
- `res_count`  out  8  completed results, wraps 255→0

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: `cmd_ready`=1; all other states drive `cmd_ready`=0.
- Accept in IDLE with `cmd_load`=0:
  - latch `alu_a`←reg[`cmd_src_a`], `alu_b`←reg[`cmd_src_b`], `alu_cl`←`cmd_op`, and latch `cmd_dst`
  - next state EXEC
- Accept in IDLE with `cmd_load`=1:
  - reg[`cmd_dst`]←`cmd_imm`, `res_data`←`cmd_imm`, `res_dst`←`cmd_dst`
  - next state RESP; `alu_*` unchanged
- EXEC (exactly one cycle):
  - reg[dst]←`alu_out`, `res_data`←`alu_out`, `res_dst`←dst
  - next state RESP
- RESP: `res_valid`=1.
  - On an edge with `res_ready`=1: `res_count` increments (mod 256), next state IDLE.
  - Otherwise hold state; `res_data`/`res_dst` are stable.
- Register file has a single write port, so no write conflicts occur. Sources are read at accept, so `src`==`dst` uses the old value.
- `alu_a`/`alu_b`/`alu_cl` hold their last values outside EXEC.
- All arithmetic is modulo 2^WIDTH. The sequencer does no arithmetic beyond the counter.

## Timing
- Reset (edge with `rst`=1):
  - state IDLE
  - `cmd_ready`=1 after reset; a command presented while `rst`=1 is not accepted
  - `res_valid`=0, `res_data`=0, `res_dst`=0, `res_count`=0
  - `alu_a`=0, `alu_b`=0, `alu_cl`=0
  - all registers 0
- Reset in EXEC or RESP aborts the operation: no register write, no count increment.
- ALU op accepted at edge N:
  - `alu_*` valid during cycle N+1
  - `res_valid` high from cycle N+2
- Load accepted at edge N: `res_valid` high from cycle N+1.
- Minimum spacing with `res_ready` tied high: ALU op every 3 cycles, load every 2 cycles.
- `res_valid` never drops without a handshake except on reset.

## Test plan
- Load r0=100, r1=50, then op `cl`=0, src_a=0, src_b=1, dst=2, with bench ALU model `out`=a+b:
  - `alu_a`=100, `alu_b`=50, `alu_cl`=0 one cycle after accept
  - `res_data`=150, `res_dst`=2 two cycles after accept
  - `res_count`=3
- Opcode sweep `cl`=0..15 on r0=100, r1=50:
  - `alu_cl` matches each opcode in order
  - each `res_data` equals the model output for that opcode
  - `res_count` advances by 16
- Backpressure: hold `res_ready`=0 for 5 cycles in RESP:
  - `res_valid`=1, `res_data` stable, `cmd_ready`=0 throughout
  - one increment only after release
- Source equals destination: r3=7, op add src_a=3, src_b=3, dst=3 → r3=14.
  - Repeating the op gives 28.
- Reset asserted in EXEC:
  - next cycle `res_valid`=0, `res_count`=0, all registers 0, `cmd_ready`=1
  - a following load r0=9 returns `res_data`=9
- 256 back-to-back loads with `res_ready`=1 → `res_count` wraps to 0.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_cmd_sequencer: valid/ready command sequencer feeding an 8-bit ALU,   |
// | with a 4-entry operand register file and result counter.  Rev 1.0        |
// +--------------------------------------------------------------------------+
module alu_cmd_sequencer #(
  parameter int WIDTH = 8,
  parameter int OPW   = 4,
  parameter int NREG  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [OPW-1:0]   cmd_op,
  input  logic [1:0]       cmd_src_a,
  input  logic [1:0]       cmd_src_b,
  input  logic [1:0]       cmd_dst,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_cl,
  input  logic [WIDTH-1:0] alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [1:0]       res_dst,
  output logic [7:0]       res_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OPW-1:0]   alu_cl_q, alu_cl_d;
  logic [1:0]       dst_q, dst_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [1:0]       res_dst_q, res_dst_d;
  logic [7:0]       res_count_q, res_count_d;

  always_comb begin
    state_d     = state_q;
    regs_d      = regs_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_cl_d    = alu_cl_q;
    dst_d       = dst_q;
    res_data_d  = res_data_q;
    res_dst_d   = res_dst_q;
    res_count_d = res_count_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_load) begin
            regs_d[cmd_dst] = cmd_imm;
            res_data_d      = cmd_imm;
            res_dst_d       = cmd_dst;
            state_d         = RESP;
          end else begin
            // Sources are sampled here, so src == dst sees the pre-op value.
            alu_a_d  = regs_q[cmd_src_a];
            alu_b_d  = regs_q[cmd_src_b];
            alu_cl_d = cmd_op;
            dst_d    = cmd_dst;
            state_d  = EXEC;
          end
        end
      end
      EXEC: begin
        regs_d[dst_q] = alu_out;
        res_data_d    = alu_out;
        res_dst_d     = dst_q;
        state_d       = RESP;
      end
      RESP: begin
        if (res_ready) begin
          res_count_d = res_count_q + 8'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_cl_q    <= '0;
      dst_q       <= '0;
      res_data_q  <= '0;
      res_dst_q   <= '0;
      res_count_q <= '0;
    end else begin
      state_q     <= state_d;
      regs_q      <= regs_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_cl_q    <= alu_cl_d;
      dst_q       <= dst_d;
      res_data_q  <= res_data_d;
      res_dst_q   <= res_dst_d;
      res_count_q <= res_count_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign res_valid = (state_q == RESP);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_cl    = alu_cl_q;
  assign res_data  = res_data_q;
  assign res_dst   = res_dst_q;
  assign res_count = res_count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_cmd_sequencer: randomized bench with a register-file/ALU model.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_load;
  logic [3:0] cmd_op;
  logic [1:0] cmd_src_a, cmd_src_b, cmd_dst;
  logic [7:0] cmd_imm;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [3:0] alu_cl;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic [1:0] res_dst;
  logic [7:0] res_count;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.WIDTH(8), .OPW(4), .NREG(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
    .cmd_op(cmd_op), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
    .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cl(alu_cl), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_dst(res_dst), .res_count(res_count)
  );

  // Bench-owned combinational ALU; opcode 0 is add.
  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] op);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~a;
      4'd6:    return a << 1;
      4'd7:    return a >> 1;
      4'd8:    return b;
      4'd9:    return a;
      4'd10:   return a + 8'd1;
      4'd11:   return a - 8'd1;
      4'd12:   return ~(a & b);
      4'd13:   return ~(a | b);
      4'd14:   return (a < b) ? 8'd1 : 8'd0;
      default: return b - a;
    endcase
  endfunction

  assign alu_out = alu_fn(alu_a, alu_b, alu_cl);

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] m_reg [4];
  logic [7:0] m_count;
  logic [7:0] m_a, m_b;
  logic [3:0] m_cl;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 8'd0;
    m_count = 8'd0;
    m_a = 8'd0; m_b = 8'd0; m_cl = 4'd0;
  endtask

  // Called and returns at a negedge with the DUT idle.
  task automatic do_cmd(input bit ld, input logic [3:0] op, input logic [1:0] sa,
                        input logic [1:0] sb, input logic [1:0] d,
                        input logic [7:0] imm, input int hold);
    logic [7:0] exp;
    exp = ld ? imm : alu_fn(m_reg[sa], m_reg[sb], op);
    check_eq("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_load = ld; cmd_op = op;
    cmd_src_a = sa; cmd_src_b = sb; cmd_dst = d; cmd_imm = imm;
    res_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_load  = 1'($urandom); cmd_op = 4'($urandom); cmd_dst = 2'($urandom);
    cmd_src_a = 2'($urandom); cmd_src_b = 2'($urandom); cmd_imm = 8'($urandom);
    if (!ld) begin
      m_a = m_reg[sa]; m_b = m_reg[sb]; m_cl = op;
      check_eq("alu_a", {24'd0, alu_a}, {24'd0, m_a});
      check_eq("alu_b", {24'd0, alu_b}, {24'd0, m_b});
      check_eq("alu_cl", {28'd0, alu_cl}, {28'd0, m_cl});
      check_eq("exec_no_valid", {31'd0, res_valid}, 32'd0);
      @(negedge clk);
    end else begin
      check_eq("load_alu_cl_hold", {28'd0, alu_cl}, {28'd0, m_cl});
      check_eq("load_alu_a_hold", {24'd0, alu_a}, {24'd0, m_a});
    end
    check_eq("res_valid", {31'd0, res_valid}, 32'd1);
    check_eq("res_data", {24'd0, res_data}, {24'd0, exp});
    check_eq("res_dst", {30'd0, res_dst}, {30'd0, d});
    check_eq("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("bp_valid", {31'd0, res_valid}, 32'd1);
      check_eq("bp_data", {24'd0, res_data}, {24'd0, exp});
      check_eq("bp_ready", {31'd0, cmd_ready}, 32'd0);
      check_eq("bp_count", {24'd0, res_count}, {24'd0, m_count});
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    m_reg[d] = exp;
    m_count  = m_count + 8'd1;
    check_eq("res_count", {24'd0, res_count}, {24'd0, m_count});
    check_eq("res_valid_drop", {31'd0, res_valid}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; res_ready = 1'b0;
    cmd_valid = 1'b1; cmd_load = 1'b1; cmd_op = 4'd0;
    cmd_src_a = 2'd0; cmd_src_b = 2'd0; cmd_dst = 2'd0; cmd_imm = 8'h55;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0; cmd_valid = 1'b0;
    check_eq("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check_eq("rst_res_data", {24'd0, res_data}, 32'd0);
    check_eq("rst_res_count", {24'd0, res_count}, 32'd0);
    check_eq("rst_alu_a", {24'd0, alu_a}, 32'd0);

    do_cmd(1'b1, 4'd0, 2'd0, 2'd0, 2'd0, 8'd100, 0);
    do_cmd(1'b1, 4'd0, 2'd0, 2'd0, 2'd1, 8'd50, 0);
    do_cmd(1'b0, 4'd0, 2'd0, 2'd1, 2'd2, 8'd0, 0);
    check_eq("first_add_count", {24'd0, res_count}, 32'd3);

    for (int op = 0; op < 16; op++)
      do_cmd(1'b0, 4'(op), 2'd0, 2'd1, 2'd2, 8'd0, 0);
    check_eq("sweep_count", {24'd0, res_count}, 32'd19);

    do_cmd(1'b0, 4'd0, 2'd0, 2'd1, 2'd2, 8'd0, 5);
    do_cmd(1'b1, 4'd0, 2'd0, 2'd0, 2'd3, 8'd7, 5);

    do_cmd(1'b0, 4'd0, 2'd3, 2'd3, 2'd3, 8'd0, 0);
    do_cmd(1'b0, 4'd0, 2'd3, 2'd3, 2'd3, 8'd0, 0);
    do_cmd(1'b0, 4'd9, 2'd3, 2'd0, 2'd1, 8'd0, 0);
    check_eq("src_eq_dst_28", {24'd0, res_data}, 32'd28);

    for (int k = 0; k < 60; k++)
      do_cmd(1'($urandom_range(0, 2) == 0), 4'($urandom), 2'($urandom), 2'($urandom),
             2'($urandom), 8'($urandom), int'($urandom_range(0, 2)));

    // Abort an operation in EXEC.
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 4'd0;
    cmd_src_a = 2'd0; cmd_src_b = 2'd1; cmd_dst = 2'd2;
    @(negedge clk);
    cmd_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_eq("abort_res_valid", {31'd0, res_valid}, 32'd0);
    check_eq("abort_res_count", {24'd0, res_count}, 32'd0);
    check_eq("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check_eq("abort_alu_b", {24'd0, alu_b}, 32'd0);
    do_cmd(1'b0, 4'd3, 2'd0, 2'd1, 2'd2, 8'd0, 0);
    do_cmd(1'b0, 4'd3, 2'd2, 2'd3, 2'd2, 8'd0, 0);
    do_cmd(1'b1, 4'd0, 2'd0, 2'd0, 2'd0, 8'd9, 0);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 256; k++)
      do_cmd(1'b1, 4'd0, 2'd0, 2'd0, 2'($urandom), 8'($urandom), 0);
    check_eq("count_wrap", {24'd0, res_count}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
